// File: rtl/winograd_input_tiler.sv
// Raster-to-tile front end for the Winograd F(2x2,3x3) path. Buffers a frame
// in a ring of four line buffers, forms zero-padded 4x4 windows at stride 2
// and streams each window out as 16 serial beats in row-major order.
// Optional build macro: WINO_IN_TRANSFORM_EN applies B^T*d*B to each window;
// without it the raw window is emitted, sign-extended to WIDTH+2 bits.
module winograd_input_tiler #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 224,
  parameter int COLS  = 224
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_data,
  output logic [3:0]       out_idx,
  output logic             out_tile_last,
  output logic             frame_done
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int TLAST = ROWS / 2 - 1;
  localparam int CLAST = COLS / 2 - 1;

  typedef enum logic [2:0] {StIdle, StFill, StLoad, StEmit, StDone} state_e;

  state_e state_q, state_d;

  logic [RW-1:0] in_row_q, t_q, need;
  logic [CW-1:0] in_col_q, c_q;
  logic [1:0]    load_q;
  logic [3:0]    idx_q;
  logic          row_done;

  logic        [WIDTH-1:0] lbuf [4][COLS];
  logic signed [WIDTH-1:0] win  [4][4];
  logic signed [WIDTH-1:0] fetch [4];
  int                      row_i [4];
  int                      col_i;
  logic signed [WIDTH+1:0] elem;

  // The final tile row only needs the last input row; its bottom row is padding.
  assign need     = (t_q == RW'(TLAST)) ? RW'(ROWS - 1) : RW'(2 * int'(t_q) + 2);
  assign row_done = (in_col_q == CW'(COLS - 1)) && (in_row_q == need);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_tile_last = 1'b0;
    frame_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFill;
      end
      StFill: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid && row_done) state_d = StLoad;
      end
      StLoad: begin
        busy = 1'b1;
        if (load_q == 2'd3) state_d = StEmit;
      end
      StEmit: begin
        busy          = 1'b1;
        out_valid     = 1'b1;
        out_tile_last = (idx_q == 4'd15) && (c_q == CW'(CLAST)) && (t_q == RW'(TLAST));
        if (out_ready && idx_q == 4'd15) begin
          if (c_q != CW'(CLAST))      state_d = StLoad;
          else if (t_q != RW'(TLAST)) state_d = StFill;
          else                        state_d = StDone;
        end
      end
      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Input position, tile position, load column and beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_row_q <= '0;
      in_col_q <= '0;
      t_q      <= '0;
      c_q      <= '0;
      load_q   <= '0;
      idx_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            in_row_q <= '0;
            in_col_q <= '0;
            t_q      <= '0;
            c_q      <= '0;
            load_q   <= '0;
            idx_q    <= '0;
          end
        end
        StFill: begin
          if (in_valid) begin
            if (in_col_q == CW'(COLS - 1)) begin
              in_col_q <= '0;
              in_row_q <= in_row_q + 1'b1;
            end else begin
              in_col_q <= in_col_q + 1'b1;
            end
          end
        end
        StLoad: load_q <= load_q + 2'd1;
        StEmit: begin
          if (out_ready) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              if (c_q == CW'(CLAST)) begin
                c_q <= '0;
                t_q <= t_q + 1'b1;
              end else begin
                c_q <= c_q + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Window column fetch; out-of-frame coordinates become zero padding.
  always_comb begin
    col_i = 2 * int'(c_q) - 1 + int'(load_q);
    for (int i = 0; i < 4; i++) begin
      row_i[i] = 2 * int'(t_q) - 1 + i;
      fetch[i] = '0;
      if (row_i[i] >= 0 && row_i[i] < ROWS && col_i >= 0 && col_i < COLS) begin
        fetch[i] = lbuf[row_i[i][1:0]][col_i[CW-1:0]];
      end
    end
  end

  // Line-buffer writes and window capture; data storage needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == StFill && in_valid) lbuf[in_row_q[1:0]][in_col_q] <= in_data;
    if (state_q == StLoad) begin
      for (int i = 0; i < 4; i++) win[i][load_q] <= fetch[i];
    end
  end

`ifdef WINO_IN_TRANSFORM_EN
  logic signed [WIDTH:0]   rp [4][4];
  logic signed [WIDTH+1:0] cp [4][4];

  // Row pass then column pass of [v0-v2, v1+v2, v2-v1, v1-v3]; exact in WIDTH+2 bits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rp[i][0] = (WIDTH+1)'(win[i][0]) - (WIDTH+1)'(win[i][2]);
      rp[i][1] = (WIDTH+1)'(win[i][1]) + (WIDTH+1)'(win[i][2]);
      rp[i][2] = (WIDTH+1)'(win[i][2]) - (WIDTH+1)'(win[i][1]);
      rp[i][3] = (WIDTH+1)'(win[i][1]) - (WIDTH+1)'(win[i][3]);
    end
    for (int j = 0; j < 4; j++) begin
      cp[0][j] = (WIDTH+2)'(rp[0][j]) - (WIDTH+2)'(rp[2][j]);
      cp[1][j] = (WIDTH+2)'(rp[1][j]) + (WIDTH+2)'(rp[2][j]);
      cp[2][j] = (WIDTH+2)'(rp[2][j]) - (WIDTH+2)'(rp[1][j]);
      cp[3][j] = (WIDTH+2)'(rp[1][j]) - (WIDTH+2)'(rp[3][j]);
    end
    elem = cp[idx_q[3:2]][idx_q[1:0]];
  end
`else
  // Raw window element, sign-extended.
  always_comb begin
    elem = (WIDTH+2)'(win[idx_q[3:2]][idx_q[1:0]]);
  end
`endif

  assign out_data = out_valid ? elem : '0;
  assign out_idx  = idx_q;

endmodule

// File: tb/tb_winograd_input_tiler.sv
// Randomized bench for winograd_input_tiler (8x12 frame). Expected beats come
// from a window/matrix model of each tile; follows WINO_IN_TRANSFORM_EN.
module tb_winograd_input_tiler;

  localparam int WIDTH = 16;
  localparam int ROWS  = 8;
  localparam int COLS  = 12;
  localparam int NPIX  = ROWS * COLS;

  logic             clk = 1'b0;
  logic             rst, start, busy;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid, out_ready;
  logic [WIDTH+1:0] out_data;
  logic [3:0]       out_idx;
  logic             out_tile_last, frame_done;

  winograd_input_tiler #(
    .WIDTH(WIDTH),
    .ROWS (ROWS),
    .COLS (COLS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_tile_last(out_tile_last),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int idx;
    int last;
    int col;
  } beat_t;

  beat_t exp_q[$];
  int    pix[ROWS][COLS];
  int    n_cmp;
  int    n_err;

  task automatic check_eq(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int px(input int r, input int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 0;
    return pix[r][c];
  endfunction

  task automatic fill_frame(input int pat);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        case (pat)
          0:       pix[r][c] = 1;
          1:       pix[r][c] = 32767;
          2:       pix[r][c] = -32768;
          3:       pix[r][c] = int'($urandom_range(65535)) - 32768;
          default: pix[r][c] = (r == 0 && c == 0) ? 5 : 0;
        endcase
      end
    end
  endtask

  // Expected stream: tiles in raster order, 16 row-major elements each.
  task automatic build_model();
    int    d[4][4];
    int    v;
    beat_t b;
`ifdef WINO_IN_TRANSFORM_EN
    int bt[4][4];
    bt = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};
`endif
    exp_q.delete();
    for (int t = 0; t < ROWS / 2; t++) begin
      for (int c = 0; c < COLS / 2; c++) begin
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) d[i][j] = px(2 * t - 1 + i, 2 * c - 1 + j);
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
`ifdef WINO_IN_TRANSFORM_EN
            v = 0;
            for (int k = 0; k < 4; k++)
              for (int l = 0; l < 4; l++) v += bt[i][k] * d[k][l] * bt[j][l];
`else
            v = d[i][j];
`endif
            b.data = v;
            b.idx  = i * 4 + j;
            b.last = (t == ROWS / 2 - 1 && c == COLS / 2 - 1 && i == 3 && j == 3) ? 1 : 0;
            b.col  = c;
            exp_q.push_back(b);
          end
        end
      end
    end
  endtask

  task automatic check_reset();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", int'(out_data), 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_tile_last", out_tile_last, 0);
    check_eq("rst_frame_done", frame_done, 0);
  endtask

  // Runs one frame; abort_at >= 0 stops after that many accepted beats.
  task automatic run_frame(input int pat, input bit rnd, input int abort_at);
    int    ptr, cyc, last_in, last_out, beats;
    bit    prev_ov, done;
    beat_t e;
    fill_frame(pat);
    build_model();
    ptr = 0; cyc = 0; last_in = 0; last_out = 0; beats = 0; prev_ov = 0; done = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    while (!done && cyc < 20000) begin
      in_valid  = rnd ? ($urandom_range(3) != 0) : 1'b1;
      in_data   = (ptr < NPIX) ? WIDTH'(pix[ptr / COLS][ptr % COLS]) : WIDTH'($urandom);
      out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      // Final-beat-accepted means this is the frame_done cycle: start must be ignored.
      start     = (ptr == NPIX && exp_q.size() == 0) ? 1'b1 : ($urandom_range(31) == 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (ptr >= NPIX) check_eq("in_ready_past_frame", in_ready, 0);
        else begin
          ptr++;
          last_in = cyc;
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check_eq("extra_beat", out_valid, 0);
        else begin
          e = exp_q[0];
          if (!prev_ov) begin
            if (e.col == 0) check_eq("lat_after_fill", cyc - last_in, 5);
            else            check_eq("lat_after_tile", cyc - last_out, 5);
          end
          check_eq("data", $signed(out_data), e.data);
          check_eq("idx", out_idx, e.idx);
          check_eq("tile_last", out_tile_last, e.last);
          if (out_ready) begin
            void'(exp_q.pop_front());
            last_out = cyc;
            beats++;
          end
        end
      end
      prev_ov = out_valid;
      if (frame_done) begin
        done = 1;
        check_eq("done_gap", cyc - last_out, 1);
        check_eq("busy_at_done", busy, 0);
        check_eq("beats_left", exp_q.size(), 0);
        check_eq("pixels_taken", ptr, NPIX);
      end
      @(posedge clk); #1;
      cyc++;
      if (abort_at >= 0 && beats >= abort_at) return;
    end
    check_eq("frame_done_seen", done, 1);
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("idle_after_done", busy, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    run_frame(0, 1'b0, -1);
    run_frame(4, 1'b0, -1);
    run_frame(1, 1'b0, -1);
    run_frame(2, 1'b1, -1);
    repeat (3) run_frame(3, 1'b1, -1);
    // Abort midway through tile row 3, then a fresh frame must be clean.
    run_frame(3, 1'b1, 3 * (COLS / 2) * 16 + 37);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset();
    rst = 1'b0;
    run_frame(3, 1'b1, -1);
    run_frame(3, 1'b0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/winograd_input_tiler.md
# winograd_input_tiler

Parametrised raster-to-tile front end for the serial Winograd F(2x2,3x3) convolution path. It accepts one frame of ROWS x COLS signed pixels in raster order over a valid/ready stream and buffers four input lines. It forms zero-padded 4x4 windows at stride 2, giving (ROWS/2) x (COLS/2) tiles per frame, and streams each tile out as 16 serial beats. When compiled in, it applies the input transform B^T·d·B before output; downstream it feeds the element-wise multiply and output-transform stage.

## Interface
- WIDTH, 16, input pixel width, signed two's complement
- ROWS, 224, frame height; must be even and >= 4
- COLS, 224, frame width; must be even and >= 4

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a frame; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until frame_done
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted on clock edges where in_valid && in_ready
- in_data  in  WIDTH  pixel, raster order
- out_valid  out  1  tile beat valid
- out_ready  in  1  downstream accepts beat when out_valid && out_ready
- out_data  out  WIDTH+2  tile element, signed
- out_idx  out  4  element index i*4+j within the tile, row-major
- out_tile_last  out  1  high on beat 15 of the final tile of the frame
- frame_done  out  1  one-cycle pulse after the final beat is accepted

## Operation
- Reset values: busy=0, in_ready=0, out_valid=0, out_data=0, out_idx=0, out_tile_last=0, frame_done=0. FSM goes to IDLE and all counters clear. Line-buffer contents are not cleared; padding is generated from counters, so stale data is never emitted.
- Reset mid-frame aborts the frame immediately. Nothing partial is emitted afterwards.
- FSM states: IDLE -> FILL on start. FILL -> LOAD once input row min(2t+2, ROWS-1) is fully received. LOAD (4 cycles) -> EMIT. EMIT (16 beats) -> LOAD for the next tile column c+1 while c < COLS/2-1. At the end of a tile row: -> FILL if t < ROWS/2-1, else -> DONE. DONE -> IDLE after one cycle.
- Tile (t,c) window d[i][j] = pixel(2t-1+i, 2c-1+j). Any coordinate outside 0..ROWS-1 or 0..COLS-1 reads as 0.
- Line storage is a ring of 4 row buffers of COLS x WIDTH. Rows 2t-1 and 2t are released after tile row t is emitted.
- in_ready=1 only in FILL. Input is blocked during LOAD/EMIT.
- Tile row 0 needs rows 0..2. Every later tile row needs two further rows. The final tile row needs one further row; its bottom row is padding.
- Transform: rows first, then columns, each pass mapping v to [v0-v2, v1+v2, v2-v1, v1-v3]. Each pass grows the value by 1 bit, so out_data is exact in WIDTH+2 bits with no saturation.
- Pixels with in_valid=1 outside FILL are not accepted. Pixels beyond ROWS*COLS are never requested.

## Timing
- The first LOAD cycle is the cycle after the handshake that completes the required row. in_ready is low in that same cycle.
- LOAD reads one window column per cycle and takes 4 cycles. out_valid first rises in the 5th cycle after LOAD entry.
- out_valid stays high with out_data/out_idx stable until accepted. out_idx increments by 1 per accepted beat.
- After beat 15 is accepted, 4 LOAD cycles follow before the next tile. The minimum tile period is 20 cycles.
- frame_done pulses in the cycle after the final beat is accepted. busy falls in the same cycle.
- A start that coincides with frame_done is ignored.

## Configuration
- WINO_IN_TRANSFORM_EN defined: out_data = (B^T·d·B)[i][j].
- WINO_IN_TRANSFORM_EN undefined: out_data = d[i][j], sign-extended to WIDTH+2. Handshake and timing are identical in both builds.

## Test plan
- ROWS=COLS=4, transform on, all pixels 1 -> tile (0,0) beats in order: 1,-2,0,0,-2,4,0,0, then eight 0s. 4 tiles total, out_tile_last on the 16th beat of tile (1,1), frame_done one cycle later.
- ROWS=COLS=4, transform off, single pixel 5 at (0,0), rest 0 -> tile (0,0) beat idx 5 = 5. All other beats of all tiles = 0.
- Transform on, all pixels 0x7FFF, 8x8 -> interior tiles are exact, with beat idx 5 = 4*32767 = 131068. No wraparound.
- Random out_ready (50% duty), 224x224 random frame -> stream equals golden model, 112*112*16 beats, out_data stable while stalled.
- Assert rst for 1 cycle midway through tile row 3, then start a new 8x8 frame -> all outputs at reset values the next cycle. The new frame's output exactly matches a clean run.
- start pulsed during busy, and in_valid held high in EMIT -> no effect, and no pixel is consumed.
